// File: rtl/customized_dac.sv
// I2S-style stereo transmitter: buffers left/right sample frames in a small FIFO,
// generates ws, and shifts each sample MSB-first onto sd one sck after every ws edge.
module customized_dac #(
  parameter int SAMPLE_W   = 24,
  parameter int SLOT_W     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                sck,
  input  logic                rst,
  input  logic                start,
  input  logic [SAMPLE_W-1:0] in_left,
  input  logic [SAMPLE_W-1:0] in_right,
  input  logic                in_valid,
  output logic                in_ready,
  output logic                ws,
  output logic                sd,
  output logic                frame_load,
  output logic                underrun
);

  localparam int FRAME_W = 2 * SLOT_W;
  localparam int CNT_W   = $clog2(FRAME_W);
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int IDX_W   = $clog2(SAMPLE_W);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(FRAME_W - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_SLOT  = CNT_W'(SLOT_W);
  localparam logic [CNT_W-1:0] CNT_SMP   = CNT_W'(SAMPLE_W);
  localparam logic [PTR_W:0]   PTR_ONE   = (PTR_W+1)'(1);
  localparam logic [PTR_W:0]   PTR_FULL  = (PTR_W+1)'(FIFO_DEPTH);

  typedef enum logic {IDLE, RUN} state_t;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    cnt_next;
  logic [CNT_W-1:0]    bit_pos;
  logic                ws_next;
  logic                sd_next;
  logic [SAMPLE_W-1:0] sample;

  logic [SAMPLE_W-1:0] fifo_l [FIFO_DEPTH];
  logic [SAMPLE_W-1:0] fifo_r [FIFO_DEPTH];
  logic [PTR_W:0]      wr_ptr;
  logic [PTR_W:0]      rd_ptr;
  logic [PTR_W:0]      count;
  logic                fifo_empty;
  logic                push;
  logic                pop;
  logic                boundary;
  logic [SAMPLE_W-1:0] tx_l;
  logic [SAMPLE_W-1:0] tx_r;

  // Handshake: a frame transfers on any posedge where in_valid && in_ready; in_ready
  // depends only on the current fill level, so a pop on the same edge never frees space early.
  assign count      = wr_ptr - rd_ptr;
  assign fifo_empty = (count == '0);
  assign in_ready   = (count != PTR_FULL);
  assign push       = in_valid && in_ready;
  assign boundary   = (state == RUN) && (cnt == CNT_LAST);
  assign pop        = boundary && !fifo_empty;
  assign cnt_next   = (cnt == CNT_LAST) ? '0 : cnt + CNT_ONE;

  // Slot position of the upcoming bit; tx regs only change at p==0 where sd is forced low.
  always_comb begin
    ws_next = (cnt_next >= CNT_SLOT);
    bit_pos = ws_next ? (cnt_next - CNT_SLOT) : cnt_next;
    sample  = ws_next ? tx_r : tx_l;
    sd_next = 1'b0;
    if (bit_pos != '0 && bit_pos <= CNT_SMP)
      sd_next = sample[IDX_W'(SAMPLE_W - int'(bit_pos))];
  end

  always_ff @(posedge sck) begin
    if (push) begin
      fifo_l[wr_ptr[PTR_W-1:0]] <= in_left;
      fifo_r[wr_ptr[PTR_W-1:0]] <= in_right;
    end
  end

  always_ff @(posedge sck or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= CNT_LAST;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      tx_l       <= '0;
      tx_r       <= '0;
      ws         <= 1'b0;
      sd         <= 1'b0;
      frame_load <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      frame_load <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= CNT_LAST;
          ws  <= 1'b0;
          sd  <= 1'b0;
          if (start) state <= RUN;
        end
        RUN: begin
          cnt <= cnt_next;
          ws  <= ws_next;
          sd  <= sd_next;
          if (boundary) begin
            if (!fifo_empty) begin
              tx_l       <= fifo_l[rd_ptr[PTR_W-1:0]];
              tx_r       <= fifo_r[rd_ptr[PTR_W-1:0]];
              frame_load <= 1'b1;
            end else begin
              tx_l     <= '0;
              tx_r     <= '0;
              underrun <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_customized_dac.sv
// Bench for customized_dac: frame-level reference model plus a slot-position deserializer.
module tb_customized_dac;

  localparam int SW = 24;
  localparam int SL = 32;
  localparam int FD = 4;

  logic          sck = 1'b0;
  logic          rst;
  logic          start;
  logic [SW-1:0] in_left;
  logic [SW-1:0] in_right;
  logic          in_valid;
  logic          in_ready;
  logic          ws;
  logic          sd;
  logic          frame_load;
  logic          underrun;

  int n_chk  = 0;
  int n_fail = 0;

  customized_dac #(.SAMPLE_W(SW), .SLOT_W(SL), .FIFO_DEPTH(FD)) dut (
    .sck(sck), .rst(rst), .start(start), .in_left(in_left), .in_right(in_right),
    .in_valid(in_valid), .in_ready(in_ready), .ws(ws), .sd(sd),
    .frame_load(frame_load), .underrun(underrun)
  );

  // ---------------- clock / reset ----------------
  always #5 sck = ~sck;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  // Frame n after start occupies RUN edges 64n..64n+63; slot position = edge index mod 64.
  logic [2*SW-1:0] m_q[$];
  logic [2*SW-1:0] m_fr;
  logic            m_run, m_act;
  int              m_n, m_pos, m_p;
  logic [SW-1:0]   m_l, m_r, m_smp;
  logic            push_ok;
  logic            e_ws, e_sd, e_fl, e_ur, e_rdy;

  always @(posedge sck or posedge rst) begin
    if (rst) begin
      m_q.delete();
      m_run = 0; m_act = 0; m_n = 0; m_pos = 0; m_l = '0; m_r = '0;
      e_ws = 0; e_sd = 0; e_fl = 0; e_ur = 0; e_rdy = 1;
    end else begin
      push_ok = in_valid && (m_q.size() < FD);
      e_fl  = 0;
      m_act = m_run;
      if (m_run) begin
        m_pos = m_n % (2*SL);
        m_n++;
        if (m_pos == 0) begin
          if (m_q.size() != 0) begin
            m_fr = m_q.pop_front();
            m_l = m_fr[2*SW-1:SW]; m_r = m_fr[SW-1:0]; e_fl = 1;
          end else begin
            m_l = '0; m_r = '0; e_ur = 1;
          end
        end
        m_p   = m_pos % SL;
        e_ws  = (m_pos >= SL);
        m_smp = e_ws ? m_r : m_l;
        e_sd  = (m_p >= 1 && m_p <= SW) ? m_smp[SW-m_p] : 1'b0;
      end else begin
        e_ws = 0; e_sd = 0;
        if (start) m_run = 1;
      end
      if (push_ok) m_q.push_back({in_left, in_right});
      e_rdy = (m_q.size() < FD);
    end
  end

  // ---------------- scoreboard ----------------
  logic [SW-1:0] exp_q[$];
  logic [SW-1:0] rx_q[$];
  logic [SW-1:0] rx_acc;
  int            fl_total;

  always @(negedge sck) begin
    if (!rst) begin
      n_chk++;
      if (ws !== e_ws || sd !== e_sd || frame_load !== e_fl || underrun !== e_ur || in_ready !== e_rdy) begin
        n_fail++;
        $display("FAIL cycle_outputs t=%0t pos=%0d: got ws=%b sd=%b fl=%b ur=%b rdy=%b, required ws=%b sd=%b fl=%b ur=%b rdy=%b",
                 $time, m_pos, ws, sd, frame_load, underrun, in_ready, e_ws, e_sd, e_fl, e_ur, e_rdy);
      end
      if (frame_load === 1'b1) fl_total++;
      // Deserialize purely by slot position, independent of the model's sample bits.
      if (m_act && (m_pos % SL) >= 1 && (m_pos % SL) <= SW) begin
        rx_acc = {rx_acc[SW-2:0], sd};
        if ((m_pos % SL) == SW) rx_q.push_back(rx_acc);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge sck);
    rst = 1; start = 0; in_valid = 0; in_left = '0; in_right = '0;
    repeat (2) @(negedge sck);
    rst = 0;
    rx_q.delete(); exp_q.delete(); fl_total = 0;
  endtask

  task automatic push_frame(input logic [SW-1:0] l, input logic [SW-1:0] r);
    @(negedge sck);
    in_valid = 1; in_left = l; in_right = r;
    @(negedge sck);
    in_valid = 0;
  endtask

  task automatic pulse_start();
    @(negedge sck);
    start = 1;
    @(negedge sck);
    start = 0;
  endtask

  task automatic wait_rx(input int n, input int budget, input string name);
    int c;
    c = 0;
    while (rx_q.size() < n && c < budget) begin
      @(negedge sck);
      c++;
    end
    n_chk++;
    if (rx_q.size() < n) begin
      n_fail++;
      $display("FAIL %s_timeout: got %0d words, required %0d", name, rx_q.size(), n);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    n_chk += 5;
    if (ws !== 1'b0)         begin n_fail++; $display("FAIL reset_ws: got %b, required 0", ws); end
    if (sd !== 1'b0)         begin n_fail++; $display("FAIL reset_sd: got %b, required 0", sd); end
    if (frame_load !== 1'b0) begin n_fail++; $display("FAIL reset_fl: got %b, required 0", frame_load); end
    if (underrun !== 1'b0)   begin n_fail++; $display("FAIL reset_ur: got %b, required 0", underrun); end
    if (in_ready !== 1'b1)   begin n_fail++; $display("FAIL reset_rdy: got %b, required 1", in_ready); end
  endtask

  task automatic test_basic_frame();
    int fl_cnt;
    do_reset();
    push_frame(24'hA5A5A5, 24'h3C3C3C);
    exp_q.push_back(24'hA5A5A5); exp_q.push_back(24'h3C3C3C);
    pulse_start();
    wait_rx(2, 200, "basic");
    repeat (70) @(negedge sck);
    fl_cnt = fl_total;
    for (int i = 0; i < 2; i++) begin
      n_chk++;
      if (rx_q.size() > i && rx_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL basic_word%0d: got %h, required %h", i, rx_q[i], exp_q[i]);
      end
    end
    n_chk++;
    if (fl_cnt != 1) begin n_fail++; $display("FAIL basic_frame_load_count: got %0d, required 1", fl_cnt); end
  endtask

  task automatic test_fifo_full();
    logic [SW-1:0] l, r;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge sck);
      if (i == 4) begin
        n_chk++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready_after4: got %b, required 0", in_ready); end
      end
      l = SW'($urandom()); r = SW'($urandom());
      in_valid = 1; in_left = l; in_right = r;
      if (i < 4) begin exp_q.push_back(l); exp_q.push_back(r); end
    end
    @(negedge sck);
    in_valid = 0;
    n_chk++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready_after5: got %b, required 0", in_ready); end
    pulse_start();
    wait_rx(8, 400, "full");
    for (int i = 0; i < 8; i++) begin
      n_chk++;
      if (rx_q.size() > i && rx_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL full_order%0d: got %h, required %h", i, rx_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_underrun();
    logic [SW-1:0] l, r;
    do_reset();
    pulse_start();
    repeat (3) @(negedge sck);
    n_chk++;
    if (underrun !== 1'b1) begin n_fail++; $display("FAIL underrun_set: got %b, required 1", underrun); end
    wait_rx(2, 200, "underrun_zero");
    for (int i = 0; i < 2; i++) begin
      n_chk++;
      if (rx_q.size() > i && rx_q[i] !== '0) begin
        n_fail++; $display("FAIL underrun_zero%0d: got %h, required 000000", i, rx_q[i]);
      end
    end
    l = SW'($urandom()); r = SW'($urandom());
    push_frame(l, r);
    wait_rx(4, 200, "underrun_late");
    n_chk += 3;
    if (rx_q.size() > 3 && rx_q[2] !== l) begin n_fail++; $display("FAIL late_left: got %h, required %h", rx_q[2], l); end
    if (rx_q.size() > 3 && rx_q[3] !== r) begin n_fail++; $display("FAIL late_right: got %h, required %h", rx_q[3], r); end
    if (underrun !== 1'b1) begin n_fail++; $display("FAIL underrun_sticky: got %b, required 1", underrun); end
  endtask

  task automatic test_full_boundary();
    logic [SW-1:0] l, r;
    int c;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      l = SW'($urandom()); r = SW'($urandom());
      push_frame(l, r);
      exp_q.push_back(l); exp_q.push_back(r);
    end
    l = SW'($urandom()); r = SW'($urandom());
    @(negedge sck);
    in_valid = 1; in_left = l; in_right = r; start = 1;
    @(negedge sck);
    start = 0;
    c = 0;
    while (frame_load !== 1'b1 && c < 10) begin @(negedge sck); c++; end
    n_chk++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL fb_ready_after_pop: got %b, required 1", in_ready); end
    @(negedge sck);
    in_valid = 0;
    n_chk++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL fb_ready_after_push: got %b, required 0", in_ready); end
    exp_q.push_back(l); exp_q.push_back(r);
    wait_rx(10, 450, "fb");
    for (int i = 0; i < 10; i++) begin
      n_chk++;
      if (rx_q.size() > i && rx_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL fb_order%0d: got %h, required %h", i, rx_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int c, fl_seen, ws_seen;
    do_reset();
    push_frame(SW'($urandom()), SW'($urandom()));
    push_frame(SW'($urandom()), SW'($urandom()));
    pulse_start();
    c = 0;
    while (!(m_act && m_pos == 40) && c < 200) begin @(negedge sck); c++; end
    rst = 1;
    #1;
    n_chk += 5;
    if (ws !== 1'b0)         begin n_fail++; $display("FAIL mid_ws: got %b, required 0", ws); end
    if (sd !== 1'b0)         begin n_fail++; $display("FAIL mid_sd: got %b, required 0", sd); end
    if (in_ready !== 1'b1)   begin n_fail++; $display("FAIL mid_rdy: got %b, required 1", in_ready); end
    if (underrun !== 1'b0)   begin n_fail++; $display("FAIL mid_ur: got %b, required 0", underrun); end
    if (frame_load !== 1'b0) begin n_fail++; $display("FAIL mid_fl: got %b, required 0", frame_load); end
    repeat (2) @(negedge sck);
    rst = 0;
    fl_seen = 0; ws_seen = 0;
    repeat (80) begin
      @(negedge sck);
      if (frame_load === 1'b1) fl_seen++;
      if (ws === 1'b1) ws_seen++;
    end
    n_chk += 2;
    if (fl_seen != 0) begin n_fail++; $display("FAIL mid_idle_fl: got %0d loads, required 0", fl_seen); end
    if (ws_seen != 0) begin n_fail++; $display("FAIL mid_idle_ws: got %0d high cycles, required 0", ws_seen); end
    pulse_start();
    repeat (3) @(negedge sck);
    n_chk++;
    if (underrun !== 1'b1) begin n_fail++; $display("FAIL mid_fifo_discarded: got ur=%b, required 1", underrun); end
  endtask

  task automatic test_back_to_back();
    localparam int NF = 1000;
    logic [SW-1:0] l, r;
    int bad;
    do_reset();
    for (int i = 0; i < 2; i++) begin
      l = SW'($urandom()); r = SW'($urandom());
      push_frame(l, r);
      exp_q.push_back(l); exp_q.push_back(r);
    end
    pulse_start();
    for (int k = 2; k < NF; k++) begin
      l = SW'($urandom()); r = SW'($urandom());
      @(negedge sck);
      in_valid = 1; in_left = l; in_right = r;
      exp_q.push_back(l); exp_q.push_back(r);
      @(negedge sck);
      in_valid = 0;
      repeat ($urandom_range(62, 62)) @(negedge sck);
    end
    wait_rx(2*NF, 400, "b2b");
    n_chk += 2;
    if (underrun !== 1'b0) begin n_fail++; $display("FAIL b2b_underrun: got %b, required 0", underrun); end
    if (fl_total != NF) begin n_fail++; $display("FAIL b2b_frame_loads: got %0d, required %0d", fl_total, NF); end
    bad = 0;
    for (int i = 0; i < 2*NF; i++) begin
      n_chk++;
      if (rx_q.size() > i && rx_q[i] !== exp_q[i]) begin
        n_fail++;
        if (bad < 5) $display("FAIL b2b_word%0d: got %h, required %h", i, rx_q[i], exp_q[i]);
        bad++;
      end
    end
  endtask

  initial begin
    rst = 1; start = 0; in_valid = 0; in_left = '0; in_right = '0;
    rx_acc = '0; fl_total = 0;
    test_reset();
    test_basic_frame();
    test_fifo_full();
    test_underrun();
    test_full_boundary();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
